// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared opcodes, FSM state encoding and width default for alu_mc
package alu_mc_pkg;

  localparam int ALU_WIDTH_DEFAULT = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_EOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle (built only with ALU_MC_MUL_EN)
// done is high during the final iteration and product already includes that iteration's add.
module alu_mul_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH_DEFAULT,
  parameter int CYCLES = WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CNT_W'(1));
  assign product = acc_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= CNT_W'(CYCLES);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and registered result/flags
// ALU_MC_MUL_EN compiles in the iterative MUL; without it opcode 1000 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH_DEFAULT,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_BUILD = 1'b1;
`else
  localparam bit MUL_BUILD = 1'b0;
`endif
  // MUL only decodes when built in and the iteration count covers the whole datapath
  localparam bit MUL_LEGAL = MUL_BUILD && (MUL_CYCLES == WIDTH);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] busw_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;
  logic             ill_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic             ill_d;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign add_sum = {1'b0, BusA} + {1'b0, BusB};
  assign sub_dif = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    ill_d = 1'b0;
    case (ALUCtrl)
      OP_AND:   res_d = BusA & BusB;
      OP_ORR:   res_d = BusA | BusB;
      OP_EOR:   res_d = BusA ^ BusB;
      OP_PASSB: res_d = BusB;
      OP_ADD: begin
        res_d = add_sum[WIDTH-1:0];
        c_d   = add_sum[WIDTH];
        v_d   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (add_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_dif[WIDTH-1:0];
        c_d   = sub_dif[WIDTH];
        v_d   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sub_dif[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_MUL:   ill_d = !MUL_LEGAL;
      default:  ill_d = 1'b1;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  assign mul_start = in_valid && in_ready_q && (ALUCtrl == OP_MUL) && MUL_LEGAL;

  alu_mul_iter #(
    .WIDTH  (WIDTH),
    .CYCLES (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .Reset   (Reset),
    .start   (mul_start),
    .a       (BusA),
    .b       (BusB),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_prod  = '0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busw_q      <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (mul_start) begin
              state_q <= ST_BUSY;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              busw_q      <= res_d;
              zero_q      <= (res_d == '0);
              neg_q       <= res_d[WIDTH-1];
              carry_q     <= c_d;
              ovf_q       <= v_d;
              ill_q       <= ill_d;
            end
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            busw_q      <= mul_prod;
            zero_q      <= (mul_prod == '0);
            neg_q       <= mul_prod[WIDTH-1];
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign BusW      = busw_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc; ALU_MC_MUL_EN switches MUL expectations on
module tb_alu_mc;

  localparam int W = 64;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         CLK       = 1'b0;
  logic         Reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] BusA      = '0;
  logic [W-1:0] BusB      = '0;
  logic [3:0]   ALUCtrl   = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] BusW;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;
  logic         Illegal;

  int checks = 0;
  int passed = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BusA      (BusA),
    .BusB      (BusB),
    .ALUCtrl   (ALUCtrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .BusW      (BusW),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Illegal   (Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] res;
    logic z, n, c, v, ill;
    int   lat;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic [W-1:0] res;
    logic z, n, c, v, ill;
    int           lat;
  } vec_t;

  // Reference behaviour from plain arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b0111: e.res = b;
      4'b0010: begin
        e.res = a + b;
        e.c   = (e.res < a);
        e.v   = ($signed(a) < 0) == ($signed(b) < 0) && (($signed(e.res) < 0) != ($signed(a) < 0));
      end
      4'b0110: begin
        e.res = a - b;
        e.c   = (a >= b);
        e.v   = (($signed(a) < 0) != ($signed(b) < 0)) && (($signed(e.res) < 0) != ($signed(a) < 0));
      end
      4'b1000: begin
        if (MUL_ON) begin
          e.res = a * b;
          e.lat = W + 1;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cycle-level model: compares outputs at each negedge, then advances on the inputs the next edge sees.
  logic m_ready = 1'b1;
  logic m_valid = 1'b0;
  logic m_pend  = 1'b0;
  int   m_wait  = 0;
  exp_t m_cur;
  exp_t m_next;

  initial forever begin
    @(negedge CLK);
    chk_b("cyc in_ready", in_ready, m_ready);
    chk_b("cyc out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk_w("cyc BusW", BusW, m_cur.res);
      chk_b("cyc Zero", Zero, m_cur.z);
      chk_b("cyc Negative", Negative, m_cur.n);
      chk_b("cyc Carry", Carry, m_cur.c);
      chk_b("cyc Overflow", Overflow, m_cur.v);
      chk_b("cyc Illegal", Illegal, m_cur.ill);
    end
    if (Reset) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_pend  = 1'b0;
    end else if (m_pend) begin
      m_wait--;
      if (m_wait == 0) begin
        m_pend  = 1'b0;
        m_valid = 1'b1;
        m_cur   = m_next;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end else if (m_ready && in_valid) begin
      m_next  = model(ALUCtrl, BusA, BusB);
      m_ready = 1'b0;
      if (m_next.lat == 1) begin
        m_valid = 1'b1;
        m_cur   = m_next;
      end else begin
        m_pend = 1'b1;
        m_wait = m_next.lat - 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t t);
    chk_w({tag, " BusW"}, BusW, t.res);
    chk_b({tag, " Zero"}, Zero, t.z);
    chk_b({tag, " Negative"}, Negative, t.n);
    chk_b({tag, " Carry"}, Carry, t.c);
    chk_b({tag, " Overflow"}, Overflow, t.v);
    chk_b({tag, " Illegal"}, Illegal, t.ill);
  endtask

  task automatic run_op(input string tag, input vec_t t);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    ALUCtrl = t.op; BusA = t.a; BusB = t.b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    BusA = {$urandom, $urandom};
    BusB = {$urandom, $urandom};
    ALUCtrl = 4'b0010;
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk_i({tag, " latency"}, n, t.lat);
    check_outputs(tag, t);
    repeat (t.hold) begin
      in_valid = 1'b1;
      ALUCtrl  = 4'b0000;
      tick();
    end
    if (t.hold > 0) check_outputs({tag, " held"}, t);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t v;
  exp_t e;

  initial begin
    vecs.push_back('{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0110, 64'd5, 64'd7, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0110, 64'd9, 64'd9, 0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 0, 64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0001, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F, 0, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0011, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0111, 64'h1234_5678_9ABC_DEF0, 64'd0, 10, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b1111, 64'd12, 64'd34, 0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1});
    if (MUL_ON) vecs.push_back('{4'b1000, 64'd3, 64'd5, 0, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 65});
    else        vecs.push_back('{4'b1000, 64'd3, 64'd5, 0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1});

    e = model(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_w("pin add res", e.res, 64'd0);
    chk_b("pin add carry", e.c, 1'b1);
    e = model(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
    chk_w("pin sub res", e.res, 64'h7FFF_FFFF_FFFF_FFFF);
    chk_b("pin sub ovf", e.v, 1'b1);
    e = model(4'b0110, 64'd5, 64'd7);
    chk_b("pin sub borrow", e.c, 1'b0);

    Reset = 1'b1;
    repeat (3) tick();
    chk_b("reset in_ready", in_ready, 1'b1);
    chk_b("reset out_valid", out_valid, 1'b0);
    chk_w("reset BusW", BusW, 64'd0);
    chk_b("reset Zero", Zero, 1'b1);
    chk_b("reset Negative", Negative, 1'b0);
    chk_b("reset Carry", Carry, 1'b0);
    chk_b("reset Overflow", Overflow, 1'b0);
    chk_b("reset Illegal", Illegal, 1'b0);
    Reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op($sformatf("v%0d", i), vecs[i]);

    // Reset wins over a handshake on the same edge.
    Reset = 1'b1; in_valid = 1'b1; ALUCtrl = 4'b0010; BusA = 64'd1; BusB = 64'd1;
    tick();
    Reset = 1'b0; in_valid = 1'b0;
    chk_b("rstprio out_valid", out_valid, 1'b0);
    chk_b("rstprio in_ready", in_ready, 1'b1);
    tick();
    chk_b("rstprio not queued", out_valid, 1'b0);

    // Reset partway through a multiply: nothing may ever be presented.
    ALUCtrl = 4'b1000; BusA = 64'd3; BusB = 64'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_b("midmul out_valid", out_valid, 1'b0);
    chk_w("midmul BusW", BusW, 64'd0);
    chk_b("midmul Zero", Zero, 1'b1);
    chk_b("midmul in_ready", in_ready, 1'b1);
    repeat (W + 5) tick();

    v = '{4'b0010, 64'd2, 64'd2, 0, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    run_op("add2p2", v);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog timeout");
  end

endmodule
